// File: rtl/wb_dma_copy_if.sv
// Pipelined Wishbone B4 bus bundle. The signal directions are named from the
// master's side: dat_o flows toward the slave and dat_i flows toward the master.
interface wb_if;
  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output clk, rst, cyc, stb, we, adr, sel, dat_o,
    input  dat_i, ack, err, stall
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_o,
    output dat_i, ack, err, stall
  );
endinterface

// File: rtl/wb_dma_copy.sv
// Block-copy DMA engine and pipelined Wishbone master.
// A copy runs as a series of chunks. For each chunk the engine reads up to
// BUF_DEPTH words into a local buffer, releases the bus for one cycle, and then
// writes those words to the destination.
module wb_dma_copy #(
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  wb_if.master             wbm
);

  localparam int unsigned BI_W  = $clog2(BUF_DEPTH);
  localparam int unsigned IDX_W = BI_W + 1;

  typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP, FIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   chunk_q, chunk_d;
  logic [IDX_W-1:0]   iss_q, iss_d;
  logic [IDX_W-1:0]   ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [LEN_W-1:0]   wdone_q, wdone_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [31:0]        adr_q, adr_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        dat_q, dat_d;
  logic [31:0]        buf_q [BUF_DEPTH];

  logic [IDX_W-1:0]   iss_nxt;
  logic [IDX_W-1:0]   ack_nxt;
  logic [IDX_W-1:0]   chunk_new;
  logic               issue;

  function automatic logic [IDX_W-1:0] chunk_of(input logic [LEN_W-1:0] r);
    if (r > LEN_W'(BUF_DEPTH)) return IDX_W'(BUF_DEPTH);
    else                       return IDX_W'(r);
  endfunction

  // Next-state logic and registered bus outputs, one step ahead of the registers
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    chunk_d   = chunk_q;
    iss_d     = iss_q;
    ack_d     = ack_q;
    error_d   = error_q;
    wdone_d   = wdone_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    iss_nxt   = iss_q + IDX_W'(1);
    ack_nxt   = ack_q + IDX_W'(1);
    issue     = stb_q && !wbm.stall;
    chunk_new = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr & 32'hFFFF_FFFC;
          dst_d   = dst_addr & 32'hFFFF_FFFC;
          error_d = 1'b0;
          wdone_d = '0;
          iss_d   = '0;
          ack_d   = '0;
          if (len_words == '0) begin
            state_d = FIN;
          end else begin
            chunk_new = chunk_of(len_words);
            chunk_d   = chunk_new;
            rem_d     = len_words - LEN_W'(chunk_new);
            cyc_d     = 1'b1;
            stb_d     = 1'b1;
            we_d      = 1'b0;
            adr_d     = src_addr & 32'hFFFF_FFFC;
            state_d   = RD;
          end
        end
      end

      RD: begin
        if (wbm.err) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          error_d = 1'b1;
          state_d = FIN;
        end else begin
          // src_q always points at the next request, so adr follows it on issue
          if (issue) begin
            iss_d = iss_nxt;
            src_d = src_q + 32'd4;
            adr_d = src_q + 32'd4;
            if (iss_nxt == chunk_q) stb_d = 1'b0;
          end
          if (wbm.ack) begin
            ack_d = ack_nxt;
            if (ack_nxt == chunk_q) begin
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
              state_d = RGAP;
            end
          end
        end
      end

      RGAP: begin
        iss_d   = '0;
        ack_d   = '0;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        adr_d   = dst_q;
        dat_d   = buf_q[0];
        state_d = WR;
      end

      WR: begin
        if (wbm.err) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          error_d = 1'b1;
          state_d = FIN;
        end else begin
          // Data for the following request is staged together with its address
          if (issue) begin
            iss_d = iss_nxt;
            dst_d = dst_q + 32'd4;
            adr_d = dst_q + 32'd4;
            dat_d = buf_q[iss_nxt[BI_W-1:0]];
            if (iss_nxt == chunk_q) stb_d = 1'b0;
          end
          if (wbm.ack) begin
            ack_d   = ack_nxt;
            wdone_d = wdone_q + LEN_W'(1);
            if (ack_nxt == chunk_q) begin
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
              we_d    = 1'b0;
              state_d = WGAP;
            end
          end
        end
      end

      WGAP: begin
        iss_d = '0;
        ack_d = '0;
        if (rem_q != '0) begin
          chunk_new = chunk_of(rem_q);
          chunk_d   = chunk_new;
          rem_d     = rem_q - LEN_W'(chunk_new);
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = 1'b0;
          adr_d     = src_q;
          state_d   = RD;
        end else begin
          state_d = FIN;
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // done is registered out of FIN, so it lines up with busy falling
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIN);
    sel_d  = stb_d ? 4'hF : 4'h0;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      iss_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      wdone_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      iss_q   <= iss_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      wdone_q <= wdone_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
  end

  // Chunk buffer capture in ack order; contents need no reset
  always_ff @(posedge clk) begin
    if (state_q == RD && wbm.ack && !wbm.err)
      buf_q[ack_q[BI_W-1:0]] <= wbm.dat_i;
  end

  assign wbm.clk   = clk;
  assign wbm.rst   = rst;
  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = stb_q;
  assign wbm.we    = we_q;
  assign wbm.adr   = adr_q;
  assign wbm.sel   = sel_q;
  assign wbm.dat_o = dat_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words_done = wdone_q;

`ifndef SYNTHESIS
  a_stb_cyc: assert property (@(posedge clk) disable iff (rst) stb_q |-> cyc_q);
  a_iss_max: assert property (@(posedge clk) disable iff (rst) iss_q <= chunk_q);
`endif

endmodule

// File: tb/tb_wb_dma_copy.sv
// Directed bench for wb_dma_copy. The slave is an in-order pipelined memory
// with optional random stall and response delay, plus one-shot err injection.
module tb_wb_dma_copy;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len_words = '0;
  logic             busy, done, error;
  logic [LEN_W-1:0] words_done;

  wb_if wbi();

  wb_dma_copy #(.BUF_DEPTH(8), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len_words  (len_words),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .words_done (words_done),
    .wbm        (wbi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int unsigned ready;
  } req_t;

  req_t        pq[$];
  logic [31:0] mem [0:4095];
  int unsigned cyc_n = 0;
  bit          rand_mode = 1'b0;
  bit          hold_en = 1'b0;
  int unsigned err_target = 0;
  int unsigned rd_pop = 0;
  int unsigned log_cyc[$];
  logic        log_we[$];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic [3:0]  log_sel[$];
  int unsigned cyc_falls = 0;
  int unsigned cyc_high = 0;
  int unsigned done_cnt = 0;
  int unsigned hold_viol = 0;
  logic        prev_cyc = 1'b0;
  logic        pend_hold = 1'b0;
  logic [31:0] hold_adr = '0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Slave memory model and bus monitor
  always @(posedge clk) begin
    cyc_n     <= cyc_n + 1;
    wbi.ack   <= 1'b0;
    wbi.err   <= 1'b0;
    wbi.stall <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    prev_cyc  <= wbi.cyc;
    if (prev_cyc && !wbi.cyc) cyc_falls <= cyc_falls + 1;
    if (wbi.cyc) cyc_high <= cyc_high + 1;
    if (done) done_cnt <= done_cnt + 1;
    pend_hold <= wbi.cyc && wbi.stb && wbi.stall;
    hold_adr  <= wbi.adr;
    if (hold_en && pend_hold && !(wbi.stb && wbi.adr == hold_adr))
      hold_viol <= hold_viol + 1;
    if (wbi.cyc && wbi.stb && !wbi.stall) begin
      pq.push_back('{we: wbi.we, adr: wbi.adr, dat: wbi.dat_o,
                     ready: cyc_n + (rand_mode ? $urandom_range(0, 3) : 0)});
      log_cyc.push_back(cyc_n);
      log_we.push_back(wbi.we);
      log_adr.push_back(wbi.adr);
      log_dat.push_back(wbi.dat_o);
      log_sel.push_back(wbi.sel);
    end
    if (pq.size() > 0 && pq[0].ready <= cyc_n) begin
      if (pq[0].we) begin
        mem[pq[0].adr[13:2]] <= pq[0].dat;
        wbi.ack <= 1'b1;
      end else begin
        rd_pop <= rd_pop + 1;
        if (rd_pop + 1 == err_target) begin
          wbi.err <= 1'b1;
        end else begin
          wbi.ack   <= 1'b1;
          wbi.dat_i <= mem[pq[0].adr[13:2]];
        end
      end
      void'(pq.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int unsigned k);
    k = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        k = i;
        break;
      end
    end
    chk("done_seen", 32'(k != 0), 32'd1);
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                        output int unsigned t0);
    @(negedge clk);
    src_addr  = s;
    dst_addr  = d;
    len_words = LEN_W'(n);
    start     = 1'b1;
    t0        = cyc_n;
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                     output int unsigned k, output int unsigned t0);
    launch(s, d, n, t0);
    wait_done(k);
  endtask

  initial begin
    int unsigned k, t0, b, n0, ri, wi, nwr;
    bit          exp_we, seen;

    for (int i = 0; i < 4096; i++) mem[i] = pat(32'(i) << 2);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_wdone", 32'(words_done), 32'd0);
    chk("rst_cyc", 32'(wbi.cyc), 32'd0);
    chk("rst_stb", 32'(wbi.stb), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // len=3, single chunk, no stall, 1-cycle ack
    b  = log_cyc.size();
    n0 = done_cnt;
    run(32'h1000, 32'h2000, 3, k, t0);
    chk("t1_done_lat", k, 32'd12);
    chk("t1_nreq", log_cyc.size() - b, 32'd6);
    for (int i = 0; i < 3; i++) begin
      chk("t1_rd_we", 32'(log_we[b+i]), 32'd0);
      chk("t1_rd_adr", log_adr[b+i], 32'h1000 + 32'(4*i));
      chk("t1_rd_cyc", log_cyc[b+i], t0 + 1 + i);
      chk("t1_wr_we", 32'(log_we[b+3+i]), 32'd1);
      chk("t1_wr_adr", log_adr[b+3+i], 32'h2000 + 32'(4*i));
      chk("t1_wr_dat", log_dat[b+3+i], pat(32'h1000 + 32'(4*i)));
    end
    chk("t1_gap", log_cyc[b+3] - log_cyc[b+2], 32'd3);
    chk("t1_sel", 32'(log_sel[b]), 32'hF);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_wdone", 32'(words_done), 32'd3);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_done_cnt", done_cnt - n0, 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // len=10 splits into chunks of 8 and 2
    b  = log_cyc.size();
    n0 = cyc_falls;
    run(32'h1100, 32'h2000, 10, k, t0);
    chk("t2_done_lat", k, 32'd30);
    chk("t2_nreq", log_cyc.size() - b, 32'd20);
    ri = 0;
    wi = 0;
    for (int i = 0; i < 20; i++) begin
      exp_we = (i >= 8 && i < 16) || i >= 18;
      chk("t2_we", 32'(log_we[b+i]), 32'(exp_we));
      if (exp_we) begin
        chk("t2_wr_adr", log_adr[b+i], 32'h2000 + 32'(4*wi));
        chk("t2_wr_dat", log_dat[b+i], pat(32'h1100 + 32'(4*wi)));
        wi++;
      end else begin
        chk("t2_rd_adr", log_adr[b+i], 32'h1100 + 32'(4*ri));
        ri++;
      end
    end
    chk("t2_cyc_falls", cyc_falls - n0, 32'd4);
    for (int i = 0; i < 10; i++)
      chk("t2_mem", mem[(32'h2000 >> 2) + i], pat(32'h1100 + 32'(4*i)));
    chk("t2_wdone", 32'(words_done), 32'd10);

    // len=5 with random stall and 1..4 cycle response delay
    rand_mode = 1'b1;
    hold_en   = 1'b1;
    b = log_cyc.size();
    run(32'h1200, 32'h2400, 5, k, t0);
    rand_mode = 1'b0;
    hold_en   = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_nreq", log_cyc.size() - b, 32'd10);
    for (int i = 0; i < 5; i++) begin
      chk("t3_rd_adr", log_adr[b+i], 32'h1200 + 32'(4*i));
      chk("t3_rd_we", 32'(log_we[b+i]), 32'd0);
      chk("t3_wr_adr", log_adr[b+5+i], 32'h2400 + 32'(4*i));
      chk("t3_wr_we", 32'(log_we[b+5+i]), 32'd1);
      chk("t3_mem", mem[(32'h2400 >> 2) + i], pat(32'h1200 + 32'(4*i)));
    end
    chk("t3_hold", hold_viol, 32'd0);
    chk("t3_wdone", 32'(words_done), 32'd5);

    // err on the 2nd read of len=4
    repeat (4) @(negedge clk);
    err_target = rd_pop + 2;
    b = log_cyc.size();
    launch(32'h1300, 32'h2600, 4, t0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (wbi.err) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t4_err_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("t4_cyc_drop", 32'(wbi.cyc), 32'd0);
    chk("t4_stb_drop", 32'(wbi.stb), 32'd0);
    wait_done(k);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_wdone", 32'(words_done), 32'd0);
    nwr = 0;
    for (int i = int'(b); i < log_we.size(); i++) if (log_we[i]) nwr++;
    chk("t4_no_writes", nwr, 32'd0);
    chk("t4_dst_intact", mem[32'h2600 >> 2], pat(32'h2600));
    err_target = 0;
    repeat (4) @(negedge clk);
    run(32'h1400, 32'h2700, 1, k, t0);
    chk("t4_error_clr", 32'(error), 32'd0);
    chk("t4_clean_wdone", 32'(words_done), 32'd1);
    chk("t4_clean_mem", mem[32'h2700 >> 2], pat(32'h1400));

    // len=0 completes without touching the bus
    n0 = cyc_high;
    run(32'h1000, 32'h2000, 0, k, t0);
    chk("t5_len0_lat", k, 32'd2);
    chk("t5_len0_nocyc", cyc_high - n0, 32'd0);
    chk("t5_len0_wdone", 32'(words_done), 32'd0);

    // start while busy is ignored
    b = log_cyc.size();
    launch(32'h1500, 32'h2800, 2, t0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd1);
    src_addr  = 32'h1600;
    dst_addr  = 32'h2900;
    len_words = LEN_W'(7);
    start     = 1'b1;
    wait_done(k);
    chk("t5_wdone", 32'(words_done), 32'd2);
    chk("t5_nreq", log_cyc.size() - b, 32'd4);
    chk("t5_rd_adr", log_adr[b], 32'h1500);
    chk("t5_mem0", mem[32'h2800 >> 2], pat(32'h1500));
    chk("t5_mem1", mem[(32'h2800 >> 2) + 1], pat(32'h1504));
    chk("t5_other_dst", mem[32'h2900 >> 2], pat(32'h2900));

    // reset in the middle of a write phase
    repeat (2) @(negedge clk);
    launch(32'h1000, 32'h2A00, 8, t0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (wbi.cyc && wbi.we) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_wr_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_cyc", 32'(wbi.cyc), 32'd0);
    chk("t6_stb", 32'(wbi.stb), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_wdone", 32'(words_done), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_late_busy", 32'(busy), 32'd0);
    chk("t6_late_wdone", 32'(words_done), 32'd0);
    run(32'h1700, 32'h2B00, 2, k, t0);
    chk("t6_after_lat", k, 32'd10);
    chk("t6_after_wdone", 32'(words_done), 32'd2);
    chk("t6_after_mem0", mem[32'h2B00 >> 2], pat(32'h1700));
    chk("t6_after_mem1", mem[(32'h2B00 >> 2) + 1], pat(32'h1704));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of run, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
